pov_motion: RTL and testbench

POV_MOTION -- requirements
Module: pov_motion

---
 rtl/pov_motion.sv | 268 ++++++++++++++++++++++++++
 tb/tb_pov_motion.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pov_motion.sv
// pov_motion: player point-of-view motion update engine.
// Keeps player position, facing vector and view-plane vector in signed
// QI.QF fixed point. One tick runs ROTF -> ROTV -> MOVE -> COMMIT, and all
// six outputs change together in COMMIT, four edges after the tick edge.
// Optional feature macro: POV_LOAD_EN adds the load / load_vec ports, which
// overwrite the whole POV while the engine is idle.
module pov_motion #(
    parameter int QI         = 12,
    parameter int QF         = 12,
    parameter int MOVE_SHIFT = 3,
    parameter int ROT_COS    = 4080,
    parameter int ROT_SIN    = 357
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   move_fwd,
    input  logic                   move_back,
    input  logic                   strafe_l,
    input  logic                   strafe_r,
    input  logic                   rot_l,
    input  logic                   rot_r,
    output logic [QI+QF-1:0]       playerX,
    output logic [QI+QF-1:0]       playerY,
    output logic [QI+QF-1:0]       facingX,
    output logic [QI+QF-1:0]       facingY,
    output logic [QI+QF-1:0]       vplaneX,
    output logic [QI+QF-1:0]       vplaneY,
    output logic                   busy
`ifdef POV_LOAD_EN
    ,
    input  logic                   load,
    input  logic [6*(QI+QF)-1:0]   load_vec
`endif
);

    localparam int W = QI + QF;

    localparam logic signed [W-1:0] COS_C  = W'(ROT_COS);
    localparam logic signed [W-1:0] SIN_C  = W'(ROT_SIN);
    localparam logic signed [W-1:0] NSIN_C = W'(-ROT_SIN);

    // Reset pose: player at (1.5, 1.5), facing +Y, view plane (-0.5, 0).
    localparam logic signed [W-1:0] RST_P  = W'(3 << (QF - 1));
    localparam logic signed [W-1:0] RST_FY = W'(1 << QF);
    localparam logic signed [W-1:0] RST_VX = W'(-(1 << (QF - 1)));
    localparam logic signed [W-1:0] ZERO_W = '0;

    localparam logic signed [W-1:0]   MAX_W   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]   MIN_W   = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W+1:0]   SAT_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0]   SAT_MIN = {3'b111, {(W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ROTF, ROTV, MOVE, COMMIT} stateType;

    stateType state_r, stateNext_s;
    logic mFwd_r, mBack_r, mStrL_r, mStrR_r, rotL_r, rotR_r;
    logic signed [W-1:0] wPlayerX_r, wPlayerY_r, wFacingX_r, wFacingY_r;
    logic signed [W-1:0] wVplaneX_r, wVplaneY_r;
    logic signed [W-1:0] rotInX_s, rotInY_s, sinSel_s, rotX_s, rotY_s;
    logic signed [W:0]   sumX_s, sumY_s;
    logic signed [W-1:0] stepFx_s, stepFy_s, stepVx_s, stepVy_s;
    logic signed [W+1:0] accX_s, accY_s;
    logic signed [W-1:0] movX_s, movY_s;
    logic                loadGo_s;
    logic signed [W-1:0] ldPx_s, ldPy_s, ldFx_s, ldFy_s, ldVx_s, ldVy_s;

    // Clamp a wide signed sum into the W-bit two's complement range.
    function automatic logic signed [W-1:0] satSum(input logic signed [W+1:0] v);
        logic signed [W-1:0] r;
        if (v > SAT_MAX) begin
            r = MAX_W;
        end else if (v < SAT_MIN) begin
            r = MIN_W;
        end else begin
            r = v[W-1:0];
        end
        return r;
    endfunction

    // Full-width product, floor-scaled back by QF, kept at W+1 bits.
    function automatic logic signed [W:0] rotTerm(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        return (W+1)'(p >>> QF);
    endfunction

`ifdef POV_LOAD_EN
    assign loadGo_s = load && (state_r == IDLE);
    assign ldPx_s   = load_vec[6*W-1:5*W];
    assign ldPy_s   = load_vec[5*W-1:4*W];
    assign ldFx_s   = load_vec[4*W-1:3*W];
    assign ldFy_s   = load_vec[3*W-1:2*W];
    assign ldVx_s   = load_vec[2*W-1:W];
    assign ldVy_s   = load_vec[W-1:0];
`else
    assign loadGo_s = 1'b0;
    assign ldPx_s   = ZERO_W;
    assign ldPy_s   = ZERO_W;
    assign ldFx_s   = ZERO_W;
    assign ldFy_s   = ZERO_W;
    assign ldVx_s   = ZERO_W;
    assign ldVy_s   = ZERO_W;
`endif

    // Next-state logic: a load in IDLE swallows a simultaneous tick.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (loadGo_s) begin
                    stateNext_s = IDLE;
                end else if (tick) begin
                    stateNext_s = ROTF;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            ROTF:    stateNext_s = ROTV;
            ROTV:    stateNext_s = MOVE;
            MOVE:    stateNext_s = COMMIT;
            COMMIT:  stateNext_s = IDLE;
            default: stateNext_s = IDLE;
        endcase
    end

    // Shared rotator: facing in ROTF, view plane otherwise; rot_r negates sine.
    always_comb begin
        rotInX_s = wFacingX_r;
        rotInY_s = wFacingY_r;
        sinSel_s = SIN_C;
        if (state_r == ROTV) begin
            rotInX_s = wVplaneX_r;
            rotInY_s = wVplaneY_r;
        end else begin
            rotInX_s = wFacingX_r;
            rotInY_s = wFacingY_r;
        end
        if (rotR_r) begin
            sinSel_s = NSIN_C;
        end else begin
            sinSel_s = SIN_C;
        end
        sumX_s = rotTerm(rotInX_s, COS_C) - rotTerm(rotInY_s, sinSel_s);
        sumY_s = rotTerm(rotInX_s, sinSel_s) + rotTerm(rotInY_s, COS_C);
        if (rotL_r != rotR_r) begin
            rotX_s = satSum({sumX_s[W], sumX_s});
            rotY_s = satSum({sumY_s[W], sumY_s});
        end else begin
            rotX_s = rotInX_s;
            rotY_s = rotInY_s;
        end
    end

    // Player step from the already-rotated vectors; opposing requests cancel.
    always_comb begin
        stepFx_s = wFacingX_r >>> MOVE_SHIFT;
        stepFy_s = wFacingY_r >>> MOVE_SHIFT;
        stepVx_s = wVplaneX_r >>> MOVE_SHIFT;
        stepVy_s = wVplaneY_r >>> MOVE_SHIFT;
        accX_s   = (W+2)'(wPlayerX_r);
        accY_s   = (W+2)'(wPlayerY_r);
        if (mFwd_r && !mBack_r) begin
            accX_s = accX_s + (W+2)'(stepFx_s);
            accY_s = accY_s + (W+2)'(stepFy_s);
        end else if (mBack_r && !mFwd_r) begin
            accX_s = accX_s - (W+2)'(stepFx_s);
            accY_s = accY_s - (W+2)'(stepFy_s);
        end else begin
            accX_s = accX_s;
            accY_s = accY_s;
        end
        if (mStrL_r && !mStrR_r) begin
            accX_s = accX_s + (W+2)'(stepVx_s);
            accY_s = accY_s + (W+2)'(stepVy_s);
        end else if (mStrR_r && !mStrL_r) begin
            accX_s = accX_s - (W+2)'(stepVx_s);
            accY_s = accY_s - (W+2)'(stepVy_s);
        end else begin
            accX_s = accX_s;
            accY_s = accY_s;
        end
        movX_s = satSum(accX_s);
        movY_s = satSum(accY_s);
    end

    // State register and registered busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_r <= stateNext_s;
            busy    <= (stateNext_s != IDLE);
        end
    end

    // Working copy of the POV plus the motion requests captured with tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            wPlayerX_r <= RST_P;
            wPlayerY_r <= RST_P;
            wFacingX_r <= ZERO_W;
            wFacingY_r <= RST_FY;
            wVplaneX_r <= RST_VX;
            wVplaneY_r <= ZERO_W;
            {mFwd_r, mBack_r, mStrL_r, mStrR_r, rotL_r, rotR_r} <= 6'b000000;
        end else if (loadGo_s) begin
            wPlayerX_r <= ldPx_s;
            wPlayerY_r <= ldPy_s;
            wFacingX_r <= ldFx_s;
            wFacingY_r <= ldFy_s;
            wVplaneX_r <= ldVx_s;
            wVplaneY_r <= ldVy_s;
        end else begin
            case (state_r)
                IDLE: begin
                    if (tick) begin
                        {mFwd_r, mBack_r, mStrL_r, mStrR_r, rotL_r, rotR_r} <=
                            {move_fwd, move_back, strafe_l, strafe_r, rot_l, rot_r};
                    end
                end
                ROTF: begin
                    wFacingX_r <= rotX_s;
                    wFacingY_r <= rotY_s;
                end
                ROTV: begin
                    wVplaneX_r <= rotX_s;
                    wVplaneY_r <= rotY_s;
                end
                MOVE: begin
                    wPlayerX_r <= movX_s;
                    wPlayerY_r <= movY_s;
                end
                default: begin
                end
            endcase
        end
    end

    // Visible POV: all six registers change together on COMMIT or load.
    always_ff @(posedge clk) begin
        if (reset) begin
            playerX <= RST_P;
            playerY <= RST_P;
            facingX <= ZERO_W;
            facingY <= RST_FY;
            vplaneX <= RST_VX;
            vplaneY <= ZERO_W;
        end else if (loadGo_s) begin
            playerX <= ldPx_s;
            playerY <= ldPy_s;
            facingX <= ldFx_s;
            facingY <= ldFy_s;
            vplaneX <= ldVx_s;
            vplaneY <= ldVy_s;
        end else if (state_r == COMMIT) begin
            playerX <= wPlayerX_r;
            playerY <= wPlayerY_r;
            facingX <= wFacingX_r;
            facingY <= wFacingY_r;
            vplaneX <= wVplaneX_r;
            vplaneY <= wVplaneY_r;
        end
    end

endmodule

// File: tb/tb_pov_motion.sv
// tb_pov_motion: randomized self-checking bench for pov_motion.
// Instance A uses default parameters; instance B uses a 90 degree rotation,
// no move shift and a 16-bit word so saturation is reachable quickly.
// Load-port scenarios are compiled in when POV_LOAD_EN is defined.
module tb_pov_motion;

    localparam int WA = 24;
    localparam int WB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, tickA, tickB;
    logic move_fwd, move_back, strafe_l, strafe_r, rot_l, rot_r;
    logic [WA-1:0] pxA, pyA, fxA, fyA, vxA, vyA;
    logic [WB-1:0] pxB, pyB, fxB, fyB, vxB, vyB;
    logic busyA, busyB;
`ifdef POV_LOAD_EN
    logic loadA, loadB;
    logic [6*WA-1:0] loadVecA;
    logic [6*WB-1:0] loadVecB;
`endif

    pov_motion dutA (
        .clk(clk), .reset(reset), .tick(tickA),
        .move_fwd(move_fwd), .move_back(move_back), .strafe_l(strafe_l),
        .strafe_r(strafe_r), .rot_l(rot_l), .rot_r(rot_r),
        .playerX(pxA), .playerY(pyA), .facingX(fxA), .facingY(fyA),
        .vplaneX(vxA), .vplaneY(vyA), .busy(busyA)
`ifdef POV_LOAD_EN
        , .load(loadA), .load_vec(loadVecA)
`endif
    );

    pov_motion #(.QI(4), .QF(12), .MOVE_SHIFT(0), .ROT_COS(0), .ROT_SIN(4096)) dutB (
        .clk(clk), .reset(reset), .tick(tickB),
        .move_fwd(move_fwd), .move_back(move_back), .strafe_l(strafe_l),
        .strafe_r(strafe_r), .rot_l(rot_l), .rot_r(rot_r),
        .playerX(pxB), .playerY(pyB), .facingX(fxB), .facingY(fyB),
        .vplaneX(vxB), .vplaneY(vyB), .busy(busyB)
`ifdef POV_LOAD_EN
        , .load(loadB), .load_vec(loadVecB)
`endif
    );

    int numChecks = 0;
    int numErrors = 0;

    // Reference POV per instance: px, py, fx, fy, vx, vy as real-valued integers.
    longint mdl [2][6];
    int     cfgW  [2] = '{24, 16};
    int     cfgMs [2] = '{3, 0};
    longint cfgC  [2] = '{4080, 0};
    longint cfgS  [2] = '{357, 4096};

    task automatic checkValue(input string tag, input longint got, input longint exp);
        numChecks++;
        if (got != exp) begin
            numErrors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint satW(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint outVal(input int idx, input int k);
        if (idx == 0) begin
            case (k)
                0: return $signed(pxA);
                1: return $signed(pyA);
                2: return $signed(fxA);
                3: return $signed(fyA);
                4: return $signed(vxA);
                default: return $signed(vyA);
            endcase
        end
        case (k)
            0: return $signed(pxB);
            1: return $signed(pyB);
            2: return $signed(fxB);
            3: return $signed(fyB);
            4: return $signed(vxB);
            default: return $signed(vyB);
        endcase
    endfunction

    function automatic longint busyVal(input int idx);
        return (idx == 0) ? longint'(busyA) : longint'(busyB);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mdl[i] = '{6144, 6144, 0, 4096, -2048, 0};
        end
    endtask

    // Rotate both vectors by +/- angle, then step the player along the new vectors.
    task automatic modelTick(input int idx, input logic [5:0] mot);
        longint fx, fy, vx, vy, c, s, dx, dy;
        int w, ms;
        w = cfgW[idx]; ms = cfgMs[idx]; c = cfgC[idx];
        fx = mdl[idx][2]; fy = mdl[idx][3]; vx = mdl[idx][4]; vy = mdl[idx][5];
        if (mot[1] != mot[0]) begin
            s = mot[1] ? cfgS[idx] : -cfgS[idx];
            mdl[idx][2] = satW(((fx * c) >>> 12) - ((fy * s) >>> 12), w);
            mdl[idx][3] = satW(((fx * s) >>> 12) + ((fy * c) >>> 12), w);
            mdl[idx][4] = satW(((vx * c) >>> 12) - ((vy * s) >>> 12), w);
            mdl[idx][5] = satW(((vx * s) >>> 12) + ((vy * c) >>> 12), w);
        end
        dx = 0; dy = 0;
        if (mot[5] && !mot[4]) begin dx += mdl[idx][2] >>> ms; dy += mdl[idx][3] >>> ms; end
        if (mot[4] && !mot[5]) begin dx -= mdl[idx][2] >>> ms; dy -= mdl[idx][3] >>> ms; end
        if (mot[3] && !mot[2]) begin dx += mdl[idx][4] >>> ms; dy += mdl[idx][5] >>> ms; end
        if (mot[2] && !mot[3]) begin dx -= mdl[idx][4] >>> ms; dy -= mdl[idx][5] >>> ms; end
        mdl[idx][0] = satW(mdl[idx][0] + dx, w);
        mdl[idx][1] = satW(mdl[idx][1] + dy, w);
    endtask

    task automatic checkAll(input int idx, input string tag);
        string names [6] = '{"px", "py", "fx", "fy", "vx", "vy"};
        for (int k = 0; k < 6; k++) begin
            checkValue($sformatf("%s_%s%0d", tag, names[k], idx), outVal(idx, k), mdl[idx][k]);
        end
    endtask

    task automatic driveMot(input logic [5:0] mot);
        {move_fwd, move_back, strafe_l, strafe_r, rot_l, rot_r} = mot;
    endtask

    task automatic setTick(input int idx, input logic v);
        if (idx == 0) tickA = v; else tickB = v;
    endtask

    // One full update: busy for four cycles, outputs frozen, then new POV.
    task automatic runTick(input int idx, input logic [5:0] mot, input logic poke);
        @(negedge clk);
        driveMot(mot);
        setTick(idx, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) driveMot(6'($urandom));
            checkValue("busy_hi", busyVal(idx), 1);
            checkAll(idx, "hold");
            setTick(idx, poke && (c == 1 || c == 2));
`ifdef POV_LOAD_EN
            if (idx == 0) begin
                loadA = poke && (c == 1);
                for (int k = 0; k < 6; k++) loadVecA[k*WA +: WA] = WA'($urandom);
            end
`endif
        end
        @(negedge clk);
        modelTick(idx, mot);
        checkValue("busy_lo", busyVal(idx), 0);
        checkAll(idx, "upd");
        @(negedge clk);
        checkValue("no_queue", busyVal(idx), 0);
    endtask

    // Reset lands while the engine sits in MOVE; the update must vanish.
    task automatic resetMid();
        @(negedge clk);
        driveMot(6'($urandom));
        tickA = 1'b1;
        @(negedge clk);
        tickA = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkValue("rstmid_busyA", busyVal(0), 0);
        checkValue("rstmid_busyB", busyVal(1), 0);
        checkAll(0, "rstmid");
        checkAll(1, "rstmid");
        @(negedge clk);
        checkValue("rstmid_idle", busyVal(0), 0);
        checkAll(0, "rstpost");
    endtask

    initial begin
        reset = 1'b1; tickA = 1'b0; tickB = 1'b0;
        driveMot(6'b000000);
`ifdef POV_LOAD_EN
        loadA = 1'b0; loadB = 1'b0; loadVecA = '0; loadVecB = '0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        modelReset();

        // Reset pose as fixed constants.
        checkValue("rst_px", outVal(0, 0), 64'sh1800);
        checkValue("rst_py", outVal(0, 1), 64'sh1800);
        checkValue("rst_fx", outVal(0, 2), 0);
        checkValue("rst_fy", outVal(0, 3), 64'sh1000);
        checkValue("rst_vx", outVal(0, 4), -2048);
        checkValue("rst_vy", outVal(0, 5), 0);
        checkValue("rst_busy", busyVal(0), 0);
        checkAll(1, "rst");

        // Quarter turn left on B.
        runTick(1, 6'b000010, 1'b0);
        checkValue("q_fx", outVal(1, 2), -4096);
        checkValue("q_fy", outVal(1, 3), 0);
        checkValue("q_vx", outVal(1, 4), 0);
        checkValue("q_vy", outVal(1, 5), -2048);

        // Forward step and cancelling requests on A.
        runTick(0, 6'b100000, 1'b1);
        checkValue("fwd_py", outVal(0, 1), 64'sh1A00);
        checkValue("fwd_px", outVal(0, 0), 64'sh1800);
        runTick(0, 6'b110000, 1'b0);
        checkValue("cancel_py", outVal(0, 1), 64'sh1A00);
        runTick(0, 6'b000000, 1'b1);
        runTick(0, 6'b001111, 1'b0);

        // Saturation on B: facing is (-1,0), back pushes +X, fwd pushes -X.
        for (int i = 0; i < 8; i++) runTick(1, 6'b010000, 1'b0);
        checkValue("sat_hi_B", outVal(1, 0), 32767);
        for (int i = 0; i < 18; i++) runTick(1, 6'b100000, 1'b0);
        checkValue("sat_lo_B", outVal(1, 0), -32768);

        // Randomized motion on A with stray ticks and reset hits.
        for (int i = 0; i < 120; i++) begin
            if (i % 25 == 13) begin
                resetMid();
            end else begin
                runTick(0, 6'($urandom), 1'($urandom));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef POV_LOAD_EN
        // Load beats a simultaneous tick, then forward steps saturate.
        @(negedge clk);
        loadA = 1'b1; tickA = 1'b1;
        loadVecA = {24'h7FFF00, 24'h000000, 24'h001000, 24'h000000, 24'h000000, 24'h000800};
        @(negedge clk);
        loadA = 1'b0; tickA = 1'b0;
        mdl[0] = '{64'h7FFF00, 0, 4096, 0, 0, 2048};
        checkValue("ld_busy", busyVal(0), 0);
        checkAll(0, "ld");
        @(negedge clk);
        checkValue("ld_drop", busyVal(0), 0);
        checkAll(0, "ldhold");
        for (int i = 0; i < 3; i++) runTick(0, 6'b100000, 1'b1);
        checkValue("sat_hi_A", outVal(0, 0), 64'sh7FFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
